// File: rtl/four_phase_pulse_sender.sv
// Source-domain half of a pulse CDC: queues event pulses and turns each one into a
// four-phase req/ack handshake toward the destination domain.
module four_phase_pulse_sender #(
    parameter int unsigned PENDING_WIDTH = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pulse_in,
    input  logic                     ack_in,
    input  logic                     clear_overflow,
    output logic                     req_out,
    output logic                     busy,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic                     done_pulse,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam logic [PENDING_WIDTH-1:0] PendMax = '1;

    state_e                   state_q, state_d;
    logic [PENDING_WIDTH-1:0] pending_q, pending_d;
    logic                     overflow_q, overflow_d;
    logic                     req_q, req_d;
    logic                     done_q, done_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;

    logic ack_sync;
    logic launch;
    logic launch_pend;
    logic launch_fast;
    logic drop;

    assign ack_sync   = ack_sync_q[SYNC_STAGES-1];
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_in};

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        done_d      = 1'b0;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        launch      = 1'b0;
        launch_pend = 1'b0;
        launch_fast = 1'b0;
        drop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A still-high ack (e.g. left over from before a reset) blocks launching.
                if (!ack_sync && ((pending_q != '0) || pulse_in)) begin
                    launch  = 1'b1;
                    state_d = StAssert;
                    req_d   = 1'b1;
                end
            end
            StAssert: begin
                if (ack_sync) begin
                    state_d = StRelease;
                    req_d   = 1'b0;
                end
            end
            StRelease: begin
                if (!ack_sync) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase

        launch_pend = launch && (pending_q != '0);
        launch_fast = launch && (pending_q == '0);

        // Fast-path launches consume the incoming pulse directly.
        if (pulse_in && !launch_fast) begin
            if (!launch_pend) begin
                if (pending_q == PendMax) begin
                    drop = 1'b1;
                end else begin
                    pending_d = pending_q + 1'b1;
                end
            end
        end else if (launch_pend) begin
            pending_d = pending_q - 1'b1;
        end

        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ack_sync_q <= '0;
        end else if (enable) begin
            state_q    <= state_d;
            req_q      <= req_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ack_sync_q <= ack_sync_d;
        end else begin
            done_q <= 1'b0;
        end
    end

    assign req_out    = req_q;
    assign done_pulse = done_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle) || (pending_q != '0);

endmodule

// File: tb/tb_four_phase_pulse_sender.sv
// Bench for four_phase_pulse_sender: a looped-back destination model plus a scoreboard
// that expects exactly one req_out rising edge per completed handshake.
module tb_four_phase_pulse_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       pulse_in = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       loop = 1'b1;
    logic       force_ack = 1'b0;
    logic       ack_in;
    logic       req_out, busy, done_pulse, overflow;
    logic [3:0] pending;
    logic [2:0] dst_q;

    logic       s_pulse = 1'b0;
    logic       s_clear = 1'b0;
    logic       s_req, s_busy, s_done, s_overflow;
    logic [1:0] s_pending;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int rises_since = 0;
    int rise_total = 0;
    int done_total = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dst_q <= '0;
        else     dst_q <= {dst_q[1:0], req_out};
    end
    assign ack_in = loop ? dst_q[2] : force_ack;

    four_phase_pulse_sender #(.PENDING_WIDTH(4), .SYNC_STAGES(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pulse_in       (pulse_in),
        .ack_in         (ack_in),
        .clear_overflow (clear_overflow),
        .req_out        (req_out),
        .busy           (busy),
        .pending        (pending),
        .done_pulse     (done_pulse),
        .overflow       (overflow)
    );

    four_phase_pulse_sender #(.PENDING_WIDTH(2), .SYNC_STAGES(2)) u_sat (
        .clk            (clk),
        .rst            (rst),
        .enable         (1'b1),
        .pulse_in       (s_pulse),
        .ack_in         (1'b0),
        .clear_overflow (s_clear),
        .req_out        (s_req),
        .busy           (s_busy),
        .pending        (s_pending),
        .done_pulse     (s_done),
        .overflow       (s_overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || req_out) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle"}, int'(busy), 0);
        tick();
        tick();
        check({name, "_sb_drain"}, sb.size(), 0);
    endtask

    // Monitor: every done_pulse pops one expectation of a single req_out rise.
    always @(negedge clk) begin
        if (rst) begin
            req_prev    = 1'b0;
            rises_since = 0;
        end else begin
            if (req_out && !req_prev) begin
                rises_since++;
                rise_total++;
            end
            req_prev = req_out;
            if (done_pulse) begin
                done_total++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    check("sb_rises_per_handshake", rises_since, sb.pop_front());
                end
                rises_since = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", int'(req_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_done", int'(done_pulse), 0);
        rst = 1'b0;
        tick();

        // Saturation on the 2-bit instance with ack held low.
        s_pulse = 1'b1;
        repeat (6) tick();
        s_pulse = 1'b0;
        check("sat_pending", int'(s_pending), 3);
        check("sat_overflow", int'(s_overflow), 1);
        check("sat_req", int'(s_req), 1);
        s_pulse = 1'b1;
        s_clear = 1'b1;
        tick();
        s_pulse = 1'b0;
        s_clear = 1'b0;
        check("sat_set_beats_clear", int'(s_overflow), 1);
        check("sat_pending_hold", int'(s_pending), 3);
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("sat_clear", int'(s_overflow), 0);

        // Single event, fast path.
        r0 = rise_total;
        d0 = done_total;
        pulse_in = 1'b1;
        sb.push_back(1);
        tick();
        pulse_in = 1'b0;
        check("single_req_latency", int'(req_out), 1);
        check("single_pending", int'(pending), 0);
        wait_idle("single");
        check("single_rises", rise_total - r0, 1);
        check("single_dones", done_total - d0, 1);

        // Burst of five.
        r0 = rise_total;
        d0 = done_total;
        pulse_in = 1'b1;
        repeat (5) begin
            sb.push_back(1);
            tick();
        end
        pulse_in = 1'b0;
        check("burst_pending_peak", int'(pending), 4);
        check("burst_req", int'(req_out), 1);
        wait_idle("burst");
        check("burst_rises", rise_total - r0, 5);
        check("burst_dones", done_total - d0, 5);
        check("burst_pending_end", int'(pending), 0);

        // Simultaneous accept and launch from pending=2.
        loop = 1'b0;
        force_ack = 1'b1;
        repeat (3) tick();
        pulse_in = 1'b1;
        tick();
        tick();
        pulse_in = 1'b0;
        check("stale_pending", int'(pending), 2);
        check("stale_req", int'(req_out), 0);
        repeat (3) sb.push_back(1);
        loop = 1'b1;
        tick();
        tick();
        check("simul_pre_req", int'(req_out), 0);
        check("simul_pre_pending", int'(pending), 2);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        check("simul_pending", int'(pending), 2);
        check("simul_req", int'(req_out), 1);
        wait_idle("simul");

        // Freeze mid-handshake.
        pulse_in = 1'b1;
        sb.push_back(1);
        tick();
        pulse_in = 1'b0;
        enable = 1'b0;
        loop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            force_ack = i[0];
            pulse_in = ~i[0];
            tick();
            check("freeze_req", int'(req_out), 1);
            check("freeze_pending", int'(pending), 0);
        end
        pulse_in = 1'b0;
        loop = 1'b1;
        enable = 1'b1;
        wait_idle("freeze");

        // Reset mid-ASSERT with ack high, then stale-ack guard.
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        check("rstmid_req_up", int'(req_out), 1);
        repeat (3) tick();
        loop = 1'b0;
        force_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("rstmid_req", int'(req_out), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_pending", int'(pending), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        pulse_in = 1'b1;
        sb.push_back(1);
        tick();
        pulse_in = 1'b0;
        check("guard_pending", int'(pending), 1);
        check("guard_req", int'(req_out), 0);
        repeat (3) tick();
        check("guard_req_hold", int'(req_out), 0);
        loop = 1'b1;
        tick();
        tick();
        check("guard_req_sync", int'(req_out), 0);
        tick();
        check("guard_req_rise", int'(req_out), 1);
        check("guard_pending_end", int'(pending), 0);
        wait_idle("guard");
        check("main_overflow", int'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
